// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: port A writeback, port B handshake, RF write and status.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              a_we;
  logic [4:0]        a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid;
  logic              b_ready;
  logic [4:0]        b_waddr;
  logic [DATA_W-1:0] b_wdata;
  logic              a_stall;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0]       pending_mask;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    input  b_ready, a_stall, rf_we, rf_waddr, rf_wdata, pending_mask, fifo_count
  );

  modport slave (
    input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    output b_ready, a_stall, rf_we, rf_waddr, rf_wdata, pending_mask, fifo_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between the single-cycle writeback path (A, priority)
// and a FIFO-buffered multi-cycle result source (B), with starvation guard and same-register kill.
module rf_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]        addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              stall_q, stall_d;

  logic        a_real, head_valid, head_live, grant_b, pop, push, kill, b_ready_c;
  logic [31:0] mask_c;

  // Arbitration, FIFO bookkeeping and starvation tracking.
  always_comb begin
    a_real     = bus.a_we && (bus.a_waddr != 5'd0);
    head_valid = (count_q != '0);
    head_live  = head_valid && live_q[rd_ptr_q];
    grant_b    = head_live && (stall_q || !a_real);
    pop        = head_valid && (!live_q[rd_ptr_q] || grant_b);
    b_ready_c  = !rst && (count_q < CNT_W'(DEPTH));
    push       = bus.b_valid && b_ready_c && (bus.b_waddr != 5'd0);
    kill       = a_real && !stall_q;

    // Order matters: kill, then pop, then push so a same-cycle enqueue survives the kill.
    live_d = live_q;
    if (kill) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == bus.a_waddr) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = 1'b1;

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    starve_d = '0;
    if (head_live && !grant_b) begin
      starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
    end
    stall_d = (starve_d == STV_W'(STARVE_LIMIT));

    mask_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) mask_c[addr_q[i]] = 1'b1;
    end
    mask_c[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      count_q  <= count_d;
      live_q   <= live_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Payload storage needs no reset; liveness gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.b_waddr;
      data_q[wr_ptr_q] <= bus.b_wdata;
    end
  end

  assign bus.rf_we        = !rst && (grant_b || kill);
  assign bus.rf_waddr     = grant_b ? addr_q[rd_ptr_q] : bus.a_waddr;
  assign bus.rf_wdata     = grant_b ? data_q[rd_ptr_q] : bus.a_wdata;
  assign bus.b_ready      = b_ready_c;
  assign bus.a_stall      = stall_q && !rst;
  assign bus.pending_mask = mask_c;
  assign bus.fifo_count   = count_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter plus hand sequences for reset-mid-drain and starvation.
module tb_rf_write_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  rf_write_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic        e_stall;
    logic [2:0]  e_cnt;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0] rf_shadow [32];
  logic        saw_r7_stale = 1'b0;

  // Shadow register file built from the write stream.
  always @(posedge clk) begin
    if (bus.rf_we) begin
      rf_shadow[bus.rf_waddr] <= bus.rf_wdata;
      if (bus.rf_waddr == 5'd7 && bus.rf_wdata == 32'h11) saw_r7_stale <= 1'b1;
    end
  end

  task automatic add(input logic r, input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                     input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic er, input logic es, input logic [2:0] ec, input logic [31:0] em);
    vec_t v;
    v.rst = r; v.a_we = awe; v.a_waddr = aa; v.a_wdata = ad;
    v.b_valid = bv; v.b_waddr = ba; v.b_wdata = bd;
    v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed;
    v.e_ready = er; v.e_stall = es; v.e_cnt = ec; v.e_mask = em;
    vq.push_back(v);
  endtask

  task automatic apply(input logic r, input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    rst = r;
    bus.a_we = awe; bus.a_waddr = aa; bus.a_wdata = ad;
    bus.b_valid = bv; bus.b_waddr = ba; bus.b_wdata = bd;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic check_cycle(input string name, input logic ew, input logic [4:0] ea,
                             input logic [31:0] ed, input logic er, input logic es,
                             input logic [2:0] ec, input logic [31:0] em);
    logic ok;
    @(negedge clk);
    n_vec++;
    ok = (bus.rf_we === ew) && (bus.b_ready === er) && (bus.a_stall === es) &&
         (bus.fifo_count === ec) && (bus.pending_mask === em);
    if (ew) ok = ok && (bus.rf_waddr === ea) && (bus.rf_wdata === ed);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got we=%b addr=%0d data=%h ready=%b stall=%b cnt=%0d mask=%h ; want we=%b addr=%0d data=%h ready=%b stall=%b cnt=%0d mask=%h",
               name, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.b_ready, bus.a_stall,
               bus.fifo_count, bus.pending_mask, ew, ea, ed, er, es, ec, em);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    //   rst awe aa  ad            bv ba  bd             we ea  ed             rdy stl cnt mask
    add(1, 1, 3,  32'h3,          0, 0,  32'h0,          0, 0,  32'h0,          0, 0, 0, 32'h0);
    add(0, 0, 0,  32'h0,          1, 5,  32'hAAAA0001,   0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          1, 5,  32'hAAAA0001,   1, 0, 1, 32'h20);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 1, 1,  32'h100,        1, 3,  32'h33,         1, 1,  32'h100,        1, 0, 0, 32'h0);
    add(0, 1, 1,  32'h101,        1, 4,  32'h44,         1, 1,  32'h101,        1, 0, 1, 32'h8);
    add(0, 1, 1,  32'h102,        1, 6,  32'h66,         1, 1,  32'h102,        1, 0, 2, 32'h18);
    add(0, 1, 1,  32'h103,        1, 8,  32'h88,         1, 1,  32'h103,        1, 0, 3, 32'h58);
    add(0, 1, 1,  32'h104,        1, 9,  32'h99,         1, 1,  32'h104,        0, 0, 4, 32'h158);
    add(0, 0, 0,  32'h0,          1, 9,  32'h99,         1, 3,  32'h33,         0, 0, 4, 32'h158);
    add(0, 0, 0,  32'h0,          1, 9,  32'h99,         1, 4,  32'h44,         1, 0, 3, 32'h150);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          1, 6,  32'h66,         1, 0, 3, 32'h340);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          1, 8,  32'h88,         1, 0, 2, 32'h300);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          1, 9,  32'h99,         1, 0, 1, 32'h200);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 0, 0,  32'h0,          1, 7,  32'h11,         0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 1, 7,  32'h22,         0, 0,  32'h0,          1, 7,  32'h22,         1, 0, 1, 32'h80);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 1, 32'h0);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 1, 0,  32'h55,         1, 0,  32'h77,         0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 0, 0,  32'h0,          1, 10, 32'hA0A0,       0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 1, 0,  32'hDEAD,       0, 0,  32'h0,          1, 10, 32'hA0A0,       1, 0, 1, 32'h400);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 0, 32'h0);
    add(0, 1, 11, 32'hB1,         1, 11, 32'hB2,         1, 11, 32'hB1,         1, 0, 0, 32'h0);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          1, 11, 32'hB2,         1, 0, 1, 32'h800);
    add(0, 0, 0,  32'h0,          0, 0,  32'h0,          0, 0,  32'h0,          1, 0, 0, 32'h0);

    apply(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].a_we, vq[i].a_waddr, vq[i].a_wdata,
            vq[i].b_valid, vq[i].b_waddr, vq[i].b_wdata);
      check_cycle($sformatf("vec%0d", i), vq[i].e_we, vq[i].e_waddr, vq[i].e_wdata,
                  vq[i].e_ready, vq[i].e_stall, vq[i].e_cnt, vq[i].e_mask);
    end

    check_val("r7_final", rf_shadow[7], 32'h22);
    check_val("r7_stale_seen", {31'd0, saw_r7_stale}, 32'h0);

    // Reset while three entries are buffered and A is writing.
    apply(0, 1, 1, 32'h201, 1, 13, 32'hD13);
    check_cycle("fill13", 1, 1, 32'h201, 1, 0, 0, 32'h0);
    apply(0, 1, 1, 32'h202, 1, 14, 32'hD14);
    check_cycle("fill14", 1, 1, 32'h202, 1, 0, 1, 32'h2000);
    apply(0, 1, 1, 32'h203, 1, 15, 32'hD15);
    check_cycle("fill15", 1, 1, 32'h203, 1, 0, 2, 32'h6000);
    apply(0, 1, 1, 32'h204, 0, 0, 32'h0);
    check_cycle("held3", 1, 1, 32'h204, 1, 0, 3, 32'hE000);
    apply(1, 1, 1, 32'h205, 0, 0, 32'h0);
    check_cycle("rst_mid", 0, 0, 32'h0, 0, 0, 3, 32'hE000);
    apply(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_cycle("post_rst", 0, 0, 32'h0, 1, 0, 0, 32'h0);
    check_cycle("post_rst2", 0, 0, 32'h0, 1, 0, 0, 32'h0);

    // Starvation: one live B entry behind continuous A writes to r2.
    apply(0, 0, 0, 32'h0, 1, 12, 32'hC0);
    check_cycle("starve_push", 0, 0, 32'h0, 1, 0, 0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      apply(0, 1, 2, 32'h300 + 32'(k), 0, 0, 32'h0);
      check_cycle($sformatf("denied%0d", k), 1, 2, 32'h300 + 32'(k), 1, 0, 1, 32'h1000);
    end
    apply(0, 1, 2, 32'h3FF, 0, 0, 32'h0);
    check_cycle("stall_slot", 1, 12, 32'hC0, 1, 1, 1, 32'h1000);
    check_cycle("after_stall", 1, 2, 32'h3FF, 1, 0, 0, 32'h0);
    check_val("r12_final", rf_shadow[12], 32'hC0);
    check_val("r2_final", rf_shadow[2], 32'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Arbitrates the single register-file write port between two requesters.
- Port A is the single-cycle writeback path: the RegDst-selected WriteReg, RegWrite and writeback data.
- Port B is a multi-cycle result source (mult/div, late load return) with a valid/ready handshake, buffered in a small FIFO.
- A has priority; B drains in idle slots. A starvation guard forces a B slot, and a same-register kill keeps write ordering correct.

Parameters:
- DATA_W, 32: write data width.
- DEPTH, 4: B FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8: consecutive denied cycles of a live B head before a_stall is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- a_we  in  1  port A write enable (RegWrite).
- a_waddr  in  5  port A destination (WriteReg).
- a_wdata  in  DATA_W  port A write data.
- b_valid  in  1  port B request valid.
- b_ready  out  1  port B can accept.
- b_waddr  in  5  port B destination.
- b_wdata  in  DATA_W  port B data.
- a_stall  out  1  core must freeze port A this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- pending_mask  out  32  bit r set means a live B write to r is buffered.
- fifo_count  out  log2(DEPTH)+1  occupied entries, live plus killed.

Behaviour:
- Reset (synchronous, rst=1 at rising clk):
  - FIFO empties; all entries become invalid; starvation counter clears.
  - a_stall=0, b_ready=0 during reset, fifo_count=0, pending_mask=0.
  - rf_we is forced 0 while rst=1. Reset mid-drain discards buffered entries; no partial write occurs.
- Port A:
  - A "real write" means a_we=1 and a_waddr!=0.
  - Passes combinationally to rf_* in the same cycle when a_stall=0. Zero latency.
  - a_we=1 with a_waddr=0 is dropped and leaves the port free for B.
- Port B accept:
  - b_ready = (fifo_count<DEPTH) and not rst. It depends only on registered state; there is no same-cycle pop bypass.
  - A transfer occurs when b_valid and b_ready.
  - b_waddr=0 is handshaken but not stored.
  - Otherwise the entry is enqueued at the tail at the clock edge with live=1.
  - Earliest RF write of an accepted entry is the next cycle.
- Drain, evaluated on the registered head:
  - Killed head (live=0): popped this cycle without using the write port. One pop per cycle maximum.
  - Live head granted when (a_stall=1) or no real A write. Drives rf_we=1, rf_waddr/rf_wdata from the head, and pops at the edge.
  - Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- Kill rule:
  - A real A write with a_stall=0 clears live on every buffered entry whose address equals a_waddr, at that clock edge. A is the newer write.
  - An entry being enqueued in that same cycle is treated as newer than A and is not killed.
  - When a_stall=1, no kill is applied.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle the head is live and not granted.
  - Clears on a B grant or when the head is not live.
  - a_stall is a registered output: it is 1 in the cycle after the counter reaches STARVE_LIMIT, and it lasts one cycle.
  - During a_stall, B owns the port unconditionally. Any a_we that cycle is ignored; the core contract is that it holds its instruction.
- pending_mask:
  - OR of one-hot(addr) over all live entries, from registered state.
  - Updated at the edge following enqueue, kill or pop. Bit 0 is always 0.
- Simultaneous cases:
  - FIFO full plus b_valid: b_ready=0 and no accept, even if a pop happens that cycle.
  - A real write while the head is live: A wins and the counter increments.
  - A write to $0 while the head is live: B is granted.

Test Plan:
- Reset with FIFO holding 3 entries and a_we=1 -> same cycle rf_we=0; next cycle fifo_count=0, pending_mask=0, b_ready=1.
- A idle; B sends {r5,0xAAAA0001} at cycle 0 -> rf_we=1, rf_waddr=5, rf_wdata=0xAAAA0001 at cycle 1; fifo_count back to 0 at cycle 2.
- Fill 4 B entries with A writing r1 every cycle -> b_ready=0 at count=4. Fifth b_valid is held, not accepted, and the entry is not lost.
- B buffers r7=0x11; A then writes r7=0x22 -> the r7 entry is killed; pending_mask bit 7 clears; rf never sees r7=0x11; final RF r7=0x22.
- A real-writes r2 continuously with one live B entry -> a_stall=1 on the cycle after 8 denied cycles; that cycle rf_* carries the B entry and ignores A; a_stall=0 on the following cycle.
- B write to r0 plus A write to r0 in the same cycle -> rf_we=0, fifo_count stays 0, b_ready handshake completes.
